// File: rtl/move_scheduler.sv
// Direction-button front end for the crossy-road player: edge detect, priority
// arbitration, a small move FIFO and a cooldown-paced valid/ready move issuer.
module move_scheduler #(
  parameter int DEPTH    = 4,
  parameter int MOVE_GAP = 5000000,
  parameter int GAP_W    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               btn,
  input  logic                     enable,
  output logic                     move_valid,
  output logic [1:0]               move_dir,
  input  logic                     move_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MOVE_GAP - 1);

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t           state;
  logic [3:0]       btn_prev;
  logic [3:0]       edges;
  logic             push_req;
  logic [1:0]       push_dir;
  logic             push;
  logic             pop;
  logic             full;
  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [GAP_W-1:0] gap_cnt;

  // Fixed priority up > left > right > down; losers are simply discarded.
  always_comb begin
    edges    = btn & ~btn_prev;
    push_req = |edges;
    push_dir = 2'd0;
    if (edges[0])      push_dir = 2'd0;
    else if (edges[2]) push_dir = 2'd2;
    else if (edges[3]) push_dir = 2'd3;
    else if (edges[1]) push_dir = 2'd1;
  end

  assign full    = (count == FULL_LVL);
  assign pop     = (state == OFFER) && move_valid && move_ready && enable;
  assign push    = push_req && enable && (!full || pop);
  assign busy    = (state != IDLE);
  assign q_level = count;

  // NOTE: the FIFO storage has no reset; occupancy is tracked by count/pointers,
  // so stale entries are never read and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dir;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev   <= 4'b1111;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
      gap_cnt    <= '0;
    end else begin
      btn_prev <= btn;

      if (push_req && enable && full && !pop) overflow <= 1'b1;

      if (!enable) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable && count != '0) begin
            state      <= OFFER;
            move_valid <= 1'b1;
            move_dir   <= mem[rd_ptr];
          end
        end
        OFFER: begin
          if (!enable) begin
            state      <= IDLE;
            move_valid <= 1'b0;
          end else if (move_ready) begin
            state      <= GAP;
            move_valid <= 1'b0;
            gap_cnt    <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (enable && count != '0) begin
              state      <= OFFER;
              move_valid <= 1'b1;
              move_dir   <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          move_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with MOVE_GAP=8, DEPTH=4; expected values
// are hand-derived cycle by cycle from the intended timing.
module tb_move_scheduler;

  localparam int DEPTH    = 4;
  localparam int MOVE_GAP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       enable;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;
  logic       busy;
  logic [2:0] q_level;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  move_scheduler #(.DEPTH(DEPTH), .MOVE_GAP(MOVE_GAP), .GAP_W(24)) dut (
    .clk(clk), .rst(rst), .btn(btn), .enable(enable),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .busy(busy), .q_level(q_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'b0000;
  endtask

  task automatic drain();
    move_ready = 1'b1;
    for (int i = 0; i < 200 && (busy || q_level != 3'd0); i++) tick();
    check("drain_done", {busy, q_level}, 32'd0);
    move_ready = 1'b0;
  endtask

  int       hs_cyc [8];
  int       hs_dir [8];
  int       n_hs;
  logic     busy_ok;
  logic     seen;
  logic     stable;

  initial begin
    rst = 1'b1; btn = 4'b0001; enable = 1'b1; move_ready = 1'b0;
    tick(); tick();
    check("rst_valid",    move_valid, 0);
    check("rst_dir",      move_dir,   0);
    check("rst_busy",     busy,       0);
    check("rst_level",    q_level,    0);
    check("rst_overflow", overflow,   0);

    // Button held through reset must not produce a move.
    rst = 1'b0;
    tick(); tick(); tick();
    btn = 4'b0000;
    tick(); tick();
    check("held_level", q_level, 0);
    check("held_valid", move_valid, 0);

    // Single up press: q_level in N+1, move_valid in N+2.
    press(4'b0001);
    check("lat_level_n1", q_level, 1);
    check("lat_valid_n1", move_valid, 0);
    tick();
    check("lat_valid_n2", move_valid, 1);
    check("lat_dir_n2",   move_dir, 0);
    drain();

    // down+left+right together: only left is kept.
    press(4'b1110);
    check("arb_level", q_level, 1);
    tick();
    check("arb_valid",    move_valid, 1);
    check("arb_dir",      move_dir, 2);
    check("arb_overflow", overflow, 0);
    drain();

    // Back-to-back up, down, right with ready tied high.
    move_ready = 1'b1;
    n_hs = 0; busy_ok = 1'b1;
    for (int k = 0; k < 36; k++) begin
      case (k)
        0: btn = 4'b0001;
        1: btn = 4'b0010;
        2: btn = 4'b1000;
        default: btn = 4'b0000;
      endcase
      if (move_valid && move_ready && n_hs < 8) begin
        hs_cyc[n_hs] = k;
        hs_dir[n_hs] = int'(move_dir);
        n_hs++;
      end
      if (k >= 2 && k <= 20 && !busy) busy_ok = 1'b0;
      tick();
    end
    btn = 4'b0000;
    check("seq_hs_count", n_hs, 3);
    check("seq_hs0_cyc", hs_cyc[0], 2);
    check("seq_hs1_gap", hs_cyc[1] - hs_cyc[0], 9);
    check("seq_hs2_gap", hs_cyc[2] - hs_cyc[1], 9);
    check("seq_dir0", hs_dir[0], 0);
    check("seq_dir1", hs_dir[1], 1);
    check("seq_dir2", hs_dir[2], 3);
    check("seq_busy_held", busy_ok, 1);
    check("seq_idle_after", busy, 0);
    move_ready = 1'b0;

    // Six presses with ready low: saturate at 4, overflow on the 5th.
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    check("fill_level4",   q_level, 4);
    check("fill_no_ovf",   overflow, 0);
    press(4'b0001);
    check("fill_ovf5",     overflow, 1);
    check("fill_level5",   q_level, 4);
    press(4'b0010);
    check("fill_level6",   q_level, 4);
    move_ready = 1'b1;
    n_hs = 0;
    for (int k = 0; k < 50; k++) begin
      if (move_valid && move_ready && n_hs < 8) begin
        hs_dir[n_hs] = int'(move_dir);
        n_hs++;
      end
      tick();
    end
    check("fill_hs_count", n_hs, 4);
    check("fill_dir0", hs_dir[0], 0);
    check("fill_dir1", hs_dir[1], 1);
    check("fill_dir2", hs_dir[2], 2);
    check("fill_dir3", hs_dir[3], 3);
    check("fill_empty", q_level, 0);
    check("ovf_sticky", overflow, 1);
    move_ready = 1'b0;

    // Drop enable during OFFER: abort and flush.
    press(4'b0001);
    tick();
    check("abort_pre_valid", move_valid, 1);
    enable = 1'b0;
    tick();
    check("abort_valid", move_valid, 0);
    check("abort_level", q_level, 0);
    check("abort_busy",  busy, 0);
    check("abort_ovf",   overflow, 1);
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen = seen | move_valid | busy;
    end
    check("reenable_no_move", seen, 0);

    // Offer held stable for 20 cycles of back-pressure.
    press(4'b0100);
    press(4'b0001);
    check("hold_valid0", move_valid, 1);
    check("hold_dir0",   move_dir, 2);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!move_valid || move_dir != 2'd2 || q_level != 3'd2) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_level",  q_level, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
